// File: rtl/synchronous_fifo_pkg.sv
// Shared helpers for the synchronous FIFO slice.
package synchronous_fifo_pkg;

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/synchronous_fifo_mem.sv
// FIFO storage array: one synchronous write port, one combinational read port, no reset.
module synchronous_fifo_mem #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Store the incoming word on an accepted write.
  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
  end

  // The read word is captured by the owner's output register, which carries the reset.
  assign r_data = mem[r_addr];

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with registered read data and combinational full/empty flags.
module synchronous_fifo
  import synchronous_fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned AW    = PTR_W - 1;

  logic [PTR_W-1:0]      w_ptr;
  logic [PTR_W-1:0]      r_ptr;
  logic                  do_write;
  logic                  do_read;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign empty    = (w_ptr == r_ptr);
  assign full     = (w_ptr[AW-1:0] == r_ptr[AW-1:0]) && (w_ptr[AW] != r_ptr[AW]);
  assign do_write = w_en && !full;
  assign do_read  = r_en && !empty;

  synchronous_fifo_mem #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk    (clk),
    .w_en   (do_write),
    .w_addr (w_ptr[AW-1:0]),
    .w_data (data_in),
    .r_addr (r_ptr[AW-1:0]),
    .r_data (mem_rdata)
  );

  // Advance pointers on accepted transfers and register the word being read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr    <= '0;
      r_ptr    <= '0;
      data_out <= '0;
    end else begin
      if (do_write) w_ptr <= w_ptr + 1'b1;
      if (do_read) begin
        r_ptr    <= r_ptr + 1'b1;
        data_out <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_synchronous_fifo.sv
// Self-checking bench for synchronous_fifo: vector table plus queue scoreboard.
module tb_synchronous_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          w_en;
  logic          r_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;

  synchronous_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_en     (w_en),
    .r_en     (r_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          w;
    logic          r;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_dout;
  int            n_cmp;
  int            n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1ns after the rising edge,
  // and compare against the queue model.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    bit acc_w;
    bit acc_r;
    @(negedge clk);
    w_en    = w;
    r_en    = r;
    data_in = d;
    acc_w = w && (sb.size() < DEPTH);
    acc_r = r && (sb.size() > 0);
    @(posedge clk);
    #1;
    if (acc_r) exp_dout = sb.pop_front();
    if (acc_w) sb.push_back(d);
    chk("mdl_dout", data_out, exp_dout);
    chk("mdl_full", full, (sb.size() == DEPTH));
    chk("mdl_empty", empty, (sb.size() == 0));
  endtask

  task automatic model_reset();
    sb.delete();
    exp_dout = '0;
  endtask

  initial begin
    vec_t v;
    n_cmp   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    w_en    = 1'b0;
    r_en    = 1'b0;
    data_in = '0;
    model_reset();

    // Fill/drain and underflow vectors with hand-derived expectations.
    for (int i = 1; i <= 8; i++) begin
      v = '{w: 1'b1, r: 1'b0, din: 8'(i * 8'h11), dout: 8'h00, full: (i == 8), empty: 1'b0};
      vecs.push_back(v);
    end
    v = '{w: 1'b1, r: 1'b0, din: 8'hFF, dout: 8'h00, full: 1'b1, empty: 1'b0};
    vecs.push_back(v);
    for (int i = 1; i <= 8; i++) begin
      v = '{w: 1'b0, r: 1'b1, din: 8'h00, dout: 8'(i * 8'h11), full: 1'b0, empty: (i == 8)};
      vecs.push_back(v);
    end
    for (int i = 0; i < 3; i++) begin
      v = '{w: 1'b0, r: 1'b1, din: 8'h00, dout: 8'h88, full: 1'b0, empty: 1'b1};
      vecs.push_back(v);
    end
    v = '{w: 1'b1, r: 1'b0, din: 8'h5A, dout: 8'h88, full: 1'b0, empty: 1'b0};
    vecs.push_back(v);
    v = '{w: 1'b0, r: 1'b1, din: 8'h00, dout: 8'h5A, full: 1'b0, empty: 1'b1};
    vecs.push_back(v);

    // Reset held 10 cycles with both enables asserted.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      w_en    = 1'b1;
      r_en    = 1'b1;
      data_in = 8'($urandom);
      @(posedge clk);
      #1;
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_dout", data_out, 8'h00);
    end
    @(negedge clk);
    w_en  = 1'b0;
    r_en  = 1'b0;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].w, vecs[i].r, vecs[i].din);
      chk($sformatf("tbl%0d_dout", i), data_out, vecs[i].dout);
      chk($sformatf("tbl%0d_full", i), full, vecs[i].full);
      chk($sformatf("tbl%0d_empty", i), empty, vecs[i].empty);
    end

    // Simultaneous read/write at occupancy 3.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 8'($urandom));
      chk("rw3_occ", sb.size(), 3);
      chk("rw3_flags", {full, empty}, 2'b00);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
    chk("rw3_drained", empty, 1'b1);

    // Simultaneous read/write when full: read wins, write dropped.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom));
    chk("full_before", full, 1'b1);
    step(1'b1, 1'b1, 8'hEE);
    chk("full_rw_full", full, 1'b0);
    chk("full_rw_occ", sb.size(), 7);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00);
    chk("full_rw_empty", empty, 1'b1);

    // Interleaved traffic across the pointer wrap, two passes.
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 40; c++) begin
        step((c % 2 == 0) && (c < 30), (c % 2 == 0) && (c >= 10), 8'($urandom));
      end
      chk("wrap_empty", empty, 1'b1);
    end

    // Asynchronous reset between edges with 5 entries stored.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom));
    @(negedge clk);
    w_en = 1'b0;
    r_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_empty", empty, 1'b1);
    chk("arst_full", full, 1'b0);
    chk("arst_dout", data_out, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'hA5);
    step(1'b0, 1'b1, 8'h00);
    chk("arst_a5", data_out, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
